// File: rtl/photon256_perm.sv
// Iterative PHOTON-256 permutation: 8x8 nibble state, UNROLL rounds
// per clock, valid/ready on both sides, one job in flight.
module photon256_perm #(
  parameter int ROUNDS = 12,
  parameter int UNROLL = 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         io_in_valid,
  output logic         io_in_ready,
  input  logic [255:0] io_state_in,
  output logic         io_out_valid,
  input  logic         io_out_ready,
  output logic [255:0] io_state_out,
  output logic [3:0]   io_round,
  output logic         io_busy
);

  if (UNROLL < 1 || ROUNDS < 1 || ROUNDS > 15 ||
      (ROUNDS % UNROLL) != 0) begin : g_bad_cfg
    $error("photon256_perm: illegal ROUNDS/UNROLL");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_e;

  localparam logic [3:0] STEP = 4'(UNROLL);
  localparam logic [3:0] LAST = 4'(ROUNDS - UNROLL);

  localparam logic [3:0] RC [16] = '{
    4'd1, 4'd3, 4'd7, 4'd14, 4'd13, 4'd11, 4'd6, 4'd12,
    4'd9, 4'd2, 4'd5, 4'd10, 4'd0, 4'd0, 4'd0, 4'd0};
  localparam logic [3:0] IC [8] = '{
    4'd0, 4'd1, 4'd3, 4'd7, 4'd15, 4'd14, 4'd12, 4'd8};
  localparam logic [3:0] SBOX [16] = '{
    4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
    4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
  localparam logic [3:0] MIX [8][8] = '{
    '{4'd2,  4'd4,  4'd2,  4'd11, 4'd2,  4'd8,  4'd5,  4'd6},
    '{4'd12, 4'd9,  4'd8,  4'd13, 4'd7,  4'd7,  4'd5,  4'd2},
    '{4'd4,  4'd4,  4'd13, 4'd13, 4'd9,  4'd4,  4'd13, 4'd9},
    '{4'd1,  4'd6,  4'd5,  4'd1,  4'd12, 4'd13, 4'd15, 4'd14},
    '{4'd15, 4'd12, 4'd9,  4'd13, 4'd14, 4'd5,  4'd14, 4'd13},
    '{4'd9,  4'd14, 4'd5,  4'd15, 4'd4,  4'd12, 4'd9,  4'd6},
    '{4'd12, 4'd2,  4'd2,  4'd10, 4'd3,  4'd1,  4'd1,  4'd14},
    '{4'd15, 4'd1,  4'd13, 4'd10, 4'd5,  4'd10, 4'd2,  4'd3}};

  // GF(2^4) multiply, reduction by x^4+x+1
  function automatic logic [3:0] gmul(logic [3:0] a, logic [3:0] b);
    logic [6:0] p;
    p = '0;
    for (int i = 0; i < 4; i++)
      if (b[i]) p = p ^ (7'(a) << i);
    for (int i = 6; i >= 4; i--)
      if (p[i]) p = p ^ (7'b0010011 << (i - 4));
    return p[3:0];
  endfunction

  function automatic logic [255:0] round_f(logic [255:0] s,
                                           logic [3:0] r);
    logic [3:0] a [8][8];
    logic [3:0] b [8][8];
    logic [3:0] acc;
    logic [255:0] o;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        a[i][j] = s[4*(8*i+j) +: 4];
    for (int i = 0; i < 8; i++)
      a[i][0] = a[i][0] ^ RC[r] ^ IC[i];
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        a[i][j] = SBOX[a[i][j]];
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        b[i][j] = a[i][(j + i) % 8];
    o = '0;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) begin
        acc = '0;
        for (int k = 0; k < 8; k++)
          acc = acc ^ gmul(MIX[i][k], b[k][j]);
        o[4*(8*i+j) +: 4] = acc;
      end
    return o;
  endfunction

  fsm_e         fsm_q, fsm_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [255:0] state_q, state_d;
  logic [255:0] rnd_out;

  always_comb begin
    rnd_out = state_q;
    for (int k = 0; k < UNROLL; k++)
      rnd_out = round_f(rnd_out, cnt_q + 4'(k));
  end

  always_comb begin
    fsm_d        = fsm_q;
    cnt_d        = cnt_q;
    state_d      = state_q;
    io_in_ready  = 1'b0;
    io_out_valid = 1'b0;
    unique case (fsm_q)
      IDLE: begin
        io_in_ready = 1'b1;
        if (io_in_valid) begin
          state_d = io_state_in;
          cnt_d   = '0;
          fsm_d   = RUN;
        end
      end
      RUN: begin
        state_d = rnd_out;
        if (cnt_q == LAST) fsm_d = DONE;
        else               cnt_d = cnt_q + STEP;
      end
      DONE: begin
        io_out_valid = 1'b1;
        if (io_out_ready) begin
          fsm_d = IDLE;
          cnt_d = '0;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fsm_q   <= IDLE;
      cnt_q   <= '0;
      state_q <= '0;
    end else begin
      fsm_q   <= fsm_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  assign io_state_out = state_q;
  assign io_round     = (fsm_q == RUN) ? cnt_q : 4'd0;
  assign io_busy      = (fsm_q != IDLE);

endmodule

// File: tb/tb_photon256_perm.sv
// Scoreboard bench for photon256_perm: default core plus UNROLL=3,
// UNROLL=12 and ROUNDS=1 variants on a shared input bus.
module tb_photon256_perm;

  localparam int RC_T [12] = '{1,3,7,14,13,11,6,12,9,2,5,10};
  localparam int IC_T [8]  = '{0,1,3,7,15,14,12,8};
  localparam int SB_T [16] = '{12,5,6,11,9,0,10,13,3,14,15,8,4,7,1,2};
  localparam int M_T [8][8] = '{
    '{2,4,2,11,2,8,5,6},
    '{12,9,8,13,7,7,5,2},
    '{4,4,13,13,9,4,13,9},
    '{1,6,5,1,12,13,15,14},
    '{15,12,9,13,14,5,14,13},
    '{9,14,5,15,4,12,9,6},
    '{12,2,2,10,3,1,1,14},
    '{15,1,13,10,5,10,2,3}};

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [255:0] st_in = '0;

  logic rdy_a, ov_a, busy_a; logic [255:0] so_a; logic [3:0] rnd_a;
  logic rdy_b, ov_b, busy_b; logic [255:0] so_b; logic [3:0] rnd_b;
  logic rdy_c, ov_c, busy_c; logic [255:0] so_c; logic [3:0] rnd_c;
  logic rdy_d, ov_d, busy_d; logic [255:0] so_d; logic [3:0] rnd_d;

  int vecs = 0;
  int errs = 0;
  logic [255:0] q_a [$];
  logic [255:0] q_b [$];
  logic [255:0] q_c [$];
  logic [255:0] vec [100];

  always #5 clock = ~clock;

  photon256_perm #(.ROUNDS(12), .UNROLL(1)) u_a (
    .clock(clock), .reset(reset),
    .io_in_valid(in_valid), .io_in_ready(rdy_a),
    .io_state_in(st_in),
    .io_out_valid(ov_a), .io_out_ready(out_ready),
    .io_state_out(so_a), .io_round(rnd_a), .io_busy(busy_a));

  photon256_perm #(.ROUNDS(12), .UNROLL(3)) u_b (
    .clock(clock), .reset(reset),
    .io_in_valid(in_valid), .io_in_ready(rdy_b),
    .io_state_in(st_in),
    .io_out_valid(ov_b), .io_out_ready(out_ready),
    .io_state_out(so_b), .io_round(rnd_b), .io_busy(busy_b));

  photon256_perm #(.ROUNDS(12), .UNROLL(12)) u_c (
    .clock(clock), .reset(reset),
    .io_in_valid(in_valid), .io_in_ready(rdy_c),
    .io_state_in(st_in),
    .io_out_valid(ov_c), .io_out_ready(out_ready),
    .io_state_out(so_c), .io_round(rnd_c), .io_busy(busy_c));

  photon256_perm #(.ROUNDS(1), .UNROLL(1)) u_d (
    .clock(clock), .reset(reset),
    .io_in_valid(in_valid), .io_in_ready(rdy_d),
    .io_state_in(st_in),
    .io_out_valid(ov_d), .io_out_ready(out_ready),
    .io_state_out(so_d), .io_round(rnd_d), .io_busy(busy_d));

  function automatic int gm(int x, int y);
    int r;
    r = 0;
    for (int i = 0; i < 4; i++) begin
      if (((y >> i) & 1) != 0) r = r ^ x;
      x = x << 1;
      if ((x & 16) != 0) x = x ^ 19;
    end
    return r;
  endfunction

  function automatic logic [255:0] model(logic [255:0] s, int nr);
    int a [8][8];
    int b [8][8];
    int acc;
    logic [255:0] o;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        a[i][j] = int'(s[4*(8*i+j) +: 4]);
    for (int r = 0; r < nr; r++) begin
      for (int i = 0; i < 8; i++) a[i][0] = a[i][0] ^ RC_T[r] ^ IC_T[i];
      for (int i = 0; i < 8; i++)
        for (int j = 0; j < 8; j++) a[i][j] = SB_T[a[i][j]];
      for (int i = 0; i < 8; i++)
        for (int j = 0; j < 8; j++) b[i][j] = a[i][(j + i) % 8];
      for (int i = 0; i < 8; i++)
        for (int j = 0; j < 8; j++) begin
          acc = 0;
          for (int k = 0; k < 8; k++) acc = acc ^ gm(M_T[i][k], b[k][j]);
          a[i][j] = acc;
        end
    end
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) o[4*(8*i+j) +: 4] = 4'(a[i][j]);
    return o;
  endfunction

  // One round on zero input: row i carries S(1^IC[i]) at column (8-i)%8
  // after ShiftRows, every other cell is S(0)=C.
  function automatic logic [3:0] hand1(int i, int j);
    int t [8][8];
    int acc;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) t[r][c] = 12;
    for (int r = 0; r < 8; r++) t[r][(8 - r) % 8] = SB_T[1 ^ IC_T[r]];
    acc = 0;
    for (int k = 0; k < 8; k++) acc = acc ^ gm(M_T[i][k], t[k][j]);
    return 4'(acc);
  endfunction

  function automatic logic [255:0] rand_state();
    logic [255:0] s;
    for (int w = 0; w < 8; w++) s[32*w +: 32] = $urandom;
    return s;
  endfunction

  task automatic wait_idle();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 40 && (busy_a | busy_b | busy_c | busy_d); i++)
      @(negedge clock);
    vecs++;
    if (busy_a | busy_b | busy_c | busy_d) begin
      errs++;
      $display("FAIL drain: busy=%b%b%b%b want 0000",
               busy_a, busy_b, busy_c, busy_d);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clock);
    vecs++;
    if ({rdy_a, ov_a, busy_a, rnd_a} !== {1'b1, 1'b0, 1'b0, 4'd0}) begin
      errs++;
      $display("FAIL reset_ctl: rdy/ov/busy/round=%b%b%b/%0d want 100/0",
               rdy_a, ov_a, busy_a, rnd_a);
    end
    vecs++;
    if (so_a !== 256'd0) begin
      errs++;
      $display("FAIL reset_state: got %h want 0", so_a);
    end
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_first_job();
    logic [255:0] exp;
    exp = model('0, 12);
    st_in = '0; in_valid = 1'b1;
    vecs++;
    if (rdy_a !== 1'b1) begin
      errs++;
      $display("FAIL idle_ready: got %b want 1", rdy_a);
    end
    @(negedge clock);
    in_valid = 1'b0;
    vecs++;
    if (rdy_a !== 1'b0) begin
      errs++;
      $display("FAIL run_ready: got %b want 0", rdy_a);
    end
    for (int k = 1; k <= 12; k++) begin
      vecs++;
      if ({ov_a, rnd_a} !== {1'b0, 4'(k - 1)}) begin
        errs++;
        $display("FAIL round_step%0d: ov/round=%b/%0d want 0/%0d",
                 k, ov_a, rnd_a, k - 1);
      end
      @(negedge clock);
    end
    vecs++;
    if (ov_a !== 1'b1 || so_a !== exp) begin
      errs++;
      $display("FAIL zero_perm: ov=%b got %h want %h", ov_a, so_a, exp);
    end
    wait_idle();
  endtask

  task automatic test_reset_abort();
    logic seen;
    st_in = rand_state(); in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    repeat (4) @(negedge clock);
    reset = 1'b0;
    #1;
    vecs++;
    if ({ov_a, rdy_a, busy_a, rnd_a} !== {1'b0, 1'b1, 1'b0, 4'd0} ||
        so_a !== 256'd0) begin
      errs++;
      $display("FAIL abort: ov/rdy/busy/round=%b%b%b/%0d state=%h want 010/0/0",
               ov_a, rdy_a, busy_a, rnd_a, so_a);
    end
    @(negedge clock);
    reset = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      if (ov_a) seen = 1'b1;
    end
    vecs++;
    if (seen !== 1'b0) begin
      errs++;
      $display("FAIL abort_ghost: out_valid seen=%b want 0", seen);
    end
  endtask

  task automatic test_backpressure();
    logic [255:0] pat, exp;
    int n;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) pat[4*(8*r+c) +: 4] = 4'((8*r+c) % 16);
    exp = model(pat, 12);
    out_ready = 1'b0; st_in = pat; in_valid = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    n = 0;
    while (!ov_a && n < 20) begin
      @(negedge clock);
      n++;
    end
    vecs++;
    if (ov_a !== 1'b1) begin
      errs++;
      $display("FAIL bp_timeout: out_valid=%b want 1", ov_a);
    end
    for (int i = 0; i < 20; i++) begin
      in_valid = i[0];
      st_in = ~pat;
      vecs++;
      if (ov_a !== 1'b1 || so_a !== exp) begin
        errs++;
        $display("FAIL bp_hold%0d: ov=%b got %h want %h", i, ov_a, so_a, exp);
      end
      @(negedge clock);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clock);
    vecs++;
    if ({ov_a, rdy_a} !== 2'b01) begin
      errs++;
      $display("FAIL bp_release: ov/rdy=%b%b want 01", ov_a, rdy_a);
    end
    repeat (3) @(negedge clock);
    vecs++;
    if (busy_a !== 1'b0) begin
      errs++;
      $display("FAIL bp_ignored: busy=%b want 0", busy_a);
    end
    wait_idle();
  endtask

  task automatic test_back_to_back();
    int idx, nout, cyc, last_hs;
    logic hs;
    logic [255:0] exp;
    for (int i = 0; i < 100; i++) vec[i] = rand_state();
    idx = 0; nout = 0; cyc = 0; last_hs = -1;
    out_ready = 1'b1; st_in = vec[0]; in_valid = 1'b1;
    while (nout < 100 && cyc < 2000) begin
      hs = 1'b0;
      if (ov_a) begin
        exp = (q_a.size() > 0) ? q_a.pop_front() : '0;
        vecs++;
        if (so_a !== exp) begin
          errs++;
          $display("FAIL b2b_out%0d: got %h want %h", nout, so_a, exp);
        end
        nout++;
      end
      if (rdy_a && in_valid) begin
        q_a.push_back(model(st_in, 12));
        if (last_hs >= 0) begin
          vecs++;
          if (cyc - last_hs != 14) begin
            errs++;
            $display("FAIL b2b_gap%0d: got %0d want 14", idx, cyc - last_hs);
          end
        end
        last_hs = cyc;
        idx++;
        hs = 1'b1;
      end
      @(posedge clock);
      #1;
      if (hs) begin
        if (idx < 100) st_in = vec[idx];
        else in_valid = 1'b0;
      end
      @(negedge clock);
      cyc++;
    end
    vecs++;
    if (nout != 100) begin
      errs++;
      $display("FAIL b2b_count: got %0d want 100", nout);
    end
    q_a.delete();
    wait_idle();
  endtask

  task automatic test_single_round();
    int k;
    logic [3:0] h;
    logic [255:0] exp;
    exp = model('0, 1);
    out_ready = 1'b1; st_in = '0; in_valid = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    k = 1;
    while (!ov_d && k < 10) begin
      @(negedge clock);
      k++;
    end
    vecs++;
    if (ov_d !== 1'b1 || k != 2) begin
      errs++;
      $display("FAIL r1_latency: ov=%b at %0d want 1 at 2", ov_d, k);
    end
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) begin
        h = hand1(i, j);
        vecs++;
        if (so_d[4*(8*i+j) +: 4] !== h) begin
          errs++;
          $display("FAIL r1_cell(%0d,%0d): got %h want %h",
                   i, j, so_d[4*(8*i+j) +: 4], h);
        end
      end
    vecs++;
    if (so_d !== exp) begin
      errs++;
      $display("FAIL r1_model: got %h want %h", so_d, exp);
    end
    wait_idle();
  endtask

  task automatic test_unrolled();
    int k;
    logic sa, sb, sc;
    logic [255:0] exp;
    out_ready = 1'b1;
    for (int v = 0; v < 100; v++) begin
      st_in = vec[v]; in_valid = 1'b1;
      exp = model(vec[v], 12);
      q_a.push_back(exp); q_b.push_back(exp); q_c.push_back(exp);
      @(negedge clock);
      in_valid = 1'b0;
      k = 1; sa = 1'b0; sb = 1'b0; sc = 1'b0;
      while (!(sa && sb && sc) && k <= 20) begin
        if (ov_b && !sb) begin
          sb = 1'b1;
          exp = q_b.pop_front();
          vecs++;
          if (k != 5 || so_b !== exp) begin
            errs++;
            $display("FAIL u3_vec%0d: lat %0d got %h want lat 5 %h",
                     v, k, so_b, exp);
          end
        end
        if (ov_c && !sc) begin
          sc = 1'b1;
          exp = q_c.pop_front();
          vecs++;
          if (k != 2 || so_c !== exp) begin
            errs++;
            $display("FAIL u12_vec%0d: lat %0d got %h want lat 2 %h",
                     v, k, so_c, exp);
          end
        end
        if (ov_a && !sa) begin
          sa = 1'b1;
          exp = q_a.pop_front();
          vecs++;
          if (k != 13 || so_a !== exp) begin
            errs++;
            $display("FAIL u1_vec%0d: lat %0d got %h want lat 13 %h",
                     v, k, so_a, exp);
          end
        end
        @(negedge clock);
        k++;
      end
      if (!(sa && sb && sc)) begin
        vecs++;
        errs++;
        $display("FAIL unroll_timeout%0d: seen=%b%b%b want 111",
                 v, sa, sb, sc);
        q_a.delete(); q_b.delete(); q_c.delete();
        wait_idle();
      end
    end
    wait_idle();
  endtask

  initial begin
    test_reset();
    test_first_job();
    test_reset_abort();
    test_backpressure();
    test_back_to_back();
    test_single_round();
    test_unrolled();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
